// File: rtl/dc_mem_responder.sv
// dc_mem_responder: memory-side responder for the data cache.
// It serves 8-word line fills as one 32-bit beat per cycle.
// It absorbs full 256-bit dirty-line writebacks.
// Fixed access latencies are modelled in front of a word-addressed array.
// Optional build macro DC_MEM_CRITICAL_FIRST_EN: when defined, a fill starts
// at the requested critical word and wraps 7->0. When undefined, every fill
// starts at word 0.
module dc_mem_responder #(
  parameter int MEM_WORDS  = 65536,
  parameter int RD_LATENCY = 4,
  parameter int WB_LATENCY = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  input  logic [31:0]  req_addr,
  output logic         req_ready,
  output logic         rsp_valid,
  output logic [31:0]  rsp_data,
  output logic [2:0]   rsp_ofst,
  output logic         rsp_last,
  input  logic         wb_valid,
  input  logic [31:0]  wb_addr,
  input  logic [255:0] wb_data,
  output logic         wb_ack,
  output logic         busy
);

  localparam int AW      = $clog2(MEM_WORDS);
  localparam int LW      = AW - 3;
  localparam int MAX_LAT = (RD_LATENCY > WB_LATENCY) ? RD_LATENCY : WB_LATENCY;
  localparam int CW      = $clog2(MAX_LAT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WB_WAIT = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_BURST   = 2'd3;

  logic [31:0] mem [MEM_WORDS];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] base_q, base_d;
  logic [2:0]    start_q, start_d;
  logic [2:0]    beat_q, beat_d;
  logic [255:0]  wb_line_q, wb_line_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic [2:0]    rsp_ofst_q, rsp_ofst_d;
  logic          rsp_last_q, rsp_last_d;
  logic          wb_ack_q, wb_ack_d;
  logic          mem_we;
  logic [2:0]    req_start;
  logic [2:0]    burst_ofst;
  logic          unused_addr_bits;

`ifdef DC_MEM_CRITICAL_FIRST_EN
  assign req_start = req_addr[4:2];
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0],
                              wb_addr[31:AW+2], wb_addr[4:0]};
`else
  assign req_start = 3'd0;
  assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[4:0],
                              wb_addr[31:AW+2], wb_addr[4:0]};
`endif

  // The beat offset wraps naturally in 3 bits, which gives the 7->0 wrap.
  assign burst_ofst = start_q + beat_q;

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ofst  = rsp_ofst_q;
  assign rsp_last  = rsp_last_q;
  assign wb_ack    = wb_ack_q;

  // Next-state logic: accept (writeback first), count latency, stream the beats.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    start_d     = start_q;
    beat_d      = beat_q;
    wb_line_d   = wb_line_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_ofst_d  = rsp_ofst_q;
    rsp_last_d  = 1'b0;
    wb_ack_d    = 1'b0;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wb_valid) begin
          wb_line_d = wb_data;
          base_d    = wb_addr[AW+1:5];
          cnt_d     = CW'(WB_LATENCY - 1);
          state_d   = S_WB_WAIT;
        end else if (req_valid) begin
          base_d  = req_addr[AW+1:5];
          start_d = req_start;
          cnt_d   = CW'(RD_LATENCY - 1);
          state_d = S_RD_WAIT;
        end
      end
      S_WB_WAIT: begin
        if (cnt_q == '0) begin
          mem_we   = 1'b1;
          wb_ack_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          beat_d  = 3'd0;
          state_d = S_BURST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BURST: begin
        rsp_valid_d = 1'b1;
        rsp_ofst_d  = burst_ofst;
        rsp_data_d  = mem[{base_q, burst_ofst}];
        rsp_last_d  = (beat_q == 3'd7);
        beat_d      = beat_q + 3'd1;
        if (beat_q == 3'd7) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      start_q     <= 3'd0;
      beat_q      <= 3'd0;
      wb_line_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_ofst_q  <= 3'd0;
      rsp_last_q  <= 1'b0;
      wb_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      start_q     <= start_d;
      beat_q      <= beat_d;
      wb_line_q   <= wb_line_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ofst_q  <= rsp_ofst_d;
      rsp_last_q  <= rsp_last_d;
      wb_ack_q    <= wb_ack_d;
    end
  end

  // Commit the buffered writeback line, all eight words in one cycle.
  // Memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 8; k++) begin
        mem[{base_q, 3'(k)}] <= wb_line_q[32*k +: 32];
      end
    end
  end

endmodule

// File: tb/tb_dc_mem_responder.sv
// Directed testbench for dc_mem_responder.
// The expected fill order follows DC_MEM_CRITICAL_FIRST_EN when defined.
module tb_dc_mem_responder;

  localparam int RD_LAT = 4;
  localparam int WB_LAT = 2;
`ifdef DC_MEM_CRITICAL_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic [31:0]  req_addr;
  logic         req_ready;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [2:0]   rsp_ofst;
  logic         rsp_last;
  logic         wb_valid;
  logic [31:0]  wb_addr;
  logic [255:0] wb_data;
  logic         wb_ack;
  logic         busy;

  int tests_run;
  int tests_failed;

  dc_mem_responder #(
    .MEM_WORDS (1024),
    .RD_LATENCY(RD_LAT),
    .WB_LATENCY(WB_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_ofst (rsp_ofst),
    .rsp_last (rsp_last),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .wb_ack   (wb_ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] first);
    logic [255:0] line;
    for (int k = 0; k < 8; k++) line[32*k +: 32] = first + 32'(k);
    return line;
  endfunction

  function automatic logic [2:0] exp_start(input logic [31:0] a);
    return CRIT ? a[4:2] : 3'd0;
  endfunction

  // Writeback: assert at a negedge, then measure the posedges until wb_ack.
  task automatic wb_write(input logic [31:0] addr, input logic [255:0] line);
    int k;
    bit seen;
    @(negedge clk);
    wb_valid = 1'b1;
    wb_addr  = addr;
    wb_data  = line;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      wb_valid = 1'b0;
      k++;
      if (k == 1) check("wb_busy", {31'd0, busy}, 32'd1);
      if (wb_ack) seen = 1'b1;
    end
    check("wb_ack_lat", 32'(k - 1), 32'(WB_LAT));
    @(negedge clk);
    check("wb_ack_pulse", {31'd0, wb_ack}, 32'd0);
    $display("[TB] writeback addr=0x%08h ack after %0d edges", addr, k - 1);
  endtask

  // Wait for the first beat (req_valid is dropped after the accepting edge),
  // then check all eight beats and the idle cycle after them.
  task automatic burst_check(input logic [31:0] addr, input logic [2:0] start,
                             input logic [255:0] line);
    int k;
    bit seen;
    logic [2:0] ofst;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      req_valid = 1'b0;
      k++;
      if (k == 1) check("fill_ready_low", {31'd0, req_ready}, 32'd0);
      if (rsp_valid) seen = 1'b1;
    end
    check("fill_lat", 32'(k - 1), 32'(RD_LAT + 1));
    for (int b = 0; b < 8; b++) begin
      if (b > 0) @(negedge clk);
      ofst = start + 3'(b);
      check("beat_valid", {31'd0, rsp_valid}, 32'd1);
      check("beat_ofst", {29'd0, rsp_ofst}, {29'd0, ofst});
      check("beat_data", rsp_data, line[32*ofst +: 32]);
      check("beat_last", {31'd0, rsp_last}, (b == 7) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("post_burst_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_burst_busy", {31'd0, busy}, 32'd0);
    $display("[TB] fill addr=0x%08h start=%0d first beat after %0d edges", addr, start, k - 1);
  endtask

  task automatic fill(input logic [31:0] addr, input logic [255:0] line);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = addr;
    burst_check(addr, exp_start(addr), line);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] line_a, line_b, line_c;
    int k;
    bit seen;
    tests_run    = 0;
    tests_failed = 0;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    wb_valid  = 1'b0;
    wb_addr   = 32'd0;
    wb_data   = '0;
    line_a = mk_line(32'hA000_0000);
    line_b = mk_line(32'hB000_0000);
    line_c = mk_line(32'hC000_0000);

    // Reset asserted mid-cycle: outputs must settle without a clock edge.
    #3 reset = 1'b0;
    #1;
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_wb_ack", {31'd0, wb_ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
    check("rst_rsp_ofst", {29'd0, rsp_ofst}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset released");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("idle_wb_ack", {31'd0, wb_ack}, 32'd0);
    end

    // Writeback followed by a fill of the same line.
    wb_write(32'h0000_1000, line_a);
    fill(32'h0000_1000, line_a);

    // Critical-word request; the order depends on the build.
    fill(32'h0000_1014, line_a);

    // Writeback and fill raised together: the writeback wins, then the fill
    // returns the freshly written data.
    wb_write(32'h0000_0200, line_c);
    @(negedge clk);
    wb_valid  = 1'b1;
    wb_addr   = 32'h0000_0200;
    wb_data   = line_b;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0208;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      wb_valid = 1'b0;
      k++;
      if (wb_ack) seen = 1'b1;
    end
    check("simul_wb_lat", 32'(k - 1), 32'(WB_LAT));
    check("simul_no_beat", {31'd0, rsp_valid}, 32'd0);
    $display("[TB] simultaneous writeback acked, fill pending");
    burst_check(32'h0000_0208, exp_start(32'h0000_0208), line_b);

    // Index aliasing with 1024 words: 0x0 maps to the same line as 0x1000.
    fill(32'h0000_0000, line_a);

    // Reset in the middle of a burst, after beat 3.
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h0000_1000;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      req_valid = 1'b0;
      k++;
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_first_beat", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);
    check("mid_beat3_valid", {31'd0, rsp_valid}, 32'd1);
    check("mid_beat3_ofst", {29'd0, rsp_ofst}, 32'd3);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] reset applied mid-burst and released");
    @(negedge clk);
    check("post_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    fill(32'h0000_0000, line_a);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
